// File: rtl/window_gather_pkg.sv
// window_gather_pkg: shared video tile geometry, quadrant/state enums and fetch-order helpers.
package window_gather_pkg;
  localparam int TILE_W = 8;
  localparam int TILE_H = 8;
  localparam int BPP    = 2;
  localparam int MASK_W = 128;

  typedef enum logic [1:0] {Q_TL, Q_TR, Q_BL, Q_BR} quadrant_e;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CAPT, S_OUT} state_e;

  function automatic logic is_last(quadrant_e q, logic [2:0] ox, logic [2:0] oy);
    return q == Q_BR || (q == Q_BL && ox == 3'd0) || (q == Q_TR && oy == 3'd0) ||
           (q == Q_TL && ox == 3'd0 && oy == 3'd0);
  endfunction

  // only called when another tile is still needed, so TR->BL and BL->BR are always valid steps
  function automatic quadrant_e next_quad(quadrant_e q, logic ox_nz);
    return q == Q_TL ? (ox_nz ? Q_TR : Q_BL) : quadrant_e'(q + 2'd1);
  endfunction
endpackage

// File: rtl/window_gather_if.sv
// window_gather_if: request, tile-memory read port and window output stream of window_gather.
interface window_gather_if import window_gather_pkg::*; #(parameter int ADDR_W = 12);
  logic              start;
  logic [2:0]        offset_x;
  logic [2:0]        offset_y;
  logic [ADDR_W-1:0] tile_base;
  logic              busy;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic [MASK_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [MASK_W-1:0] window;

  modport master (
    input  start, offset_x, offset_y, tile_base, mem_gnt, mem_rdata, out_ready,
    output busy, mem_req, mem_addr, out_valid, window
  );
  modport slave (
    output start, offset_x, offset_y, tile_base, mem_gnt, mem_rdata, out_ready,
    input  busy, mem_req, mem_addr, out_valid, window
  );
endinterface

// File: rtl/window_place.sv
// window_place: places the pixels of one quadrant tile that fall inside the offset window.
module window_place import window_gather_pkg::*; (
  input  quadrant_e         quad,
  input  logic [2:0]        offset_x,
  input  logic [2:0]        offset_y,
  input  logic [MASK_W-1:0] tile,
  output logic [MASK_W-1:0] contrib
);
  logic [3:0] sr;
  logic [3:0] sc;

  // each window pixel maps to one source pixel in the 16x16 field; keep it only if it lies in quad
  always_comb begin
    contrib = '0;
    sr = '0;
    sc = '0;
    for (int r = 0; r < TILE_H; r++)
      for (int c = 0; c < TILE_W; c++) begin
        sr = 4'(r) + {1'b0, offset_y};
        sc = 4'(c) + {1'b0, offset_x};
        if ({sr[3], sc[3]} == quad)
          contrib[r*TILE_W*BPP + c*BPP +: BPP] = tile[{sr[2:0], sc[2:0], 1'b0} +: BPP];
      end
  end
endmodule

// File: rtl/window_gather.sv
// window_gather: fetches up to four neighbouring tiles and assembles the 128-bit offset window.
module window_gather import window_gather_pkg::*; #(
  parameter int ADDR_W    = 12,
  parameter int ROW_TILES = 40
) (
  input logic            clk,
  input logic            reset,
  input logic            clk_en,
  window_gather_if.master bus
);
  state_e            state_q, state_d;
  quadrant_e         quad_q, quad_d;
  logic [2:0]        ox_q, ox_d;
  logic [2:0]        oy_q, oy_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [MASK_W-1:0] acc_q, acc_d;
  logic              busy_q, busy_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic [MASK_W-1:0] contrib;
  logic              last;

  window_place u_place (
    .quad     (quad_q),
    .offset_x (ox_q),
    .offset_y (oy_q),
    .tile     (bus.mem_rdata),
    .contrib  (contrib)
  );

  assign last = is_last(quad_q, ox_q, oy_q);

  always_comb begin
    state_d = state_q;
    quad_d  = quad_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    base_d  = base_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_REQ;
        quad_d  = Q_TL;
        ox_d    = bus.offset_x;
        oy_d    = bus.offset_y;
        base_d  = bus.tile_base;
        acc_d   = '0;
      end
      S_REQ:  state_d = bus.mem_gnt ? S_CAPT : S_REQ;
      S_CAPT: begin
        acc_d   = acc_q | contrib;
        state_d = last ? S_OUT : S_REQ;
        quad_d  = last ? quad_q : next_quad(quad_q, ox_q != 3'd0);
      end
      S_OUT:  state_d = bus.out_ready ? S_IDLE : S_OUT;
      default: state_d = S_IDLE;
    endcase
    busy_d  = state_d != S_IDLE;
    req_d   = state_d == S_REQ;
    valid_d = state_d == S_OUT;
  end

  always_ff @(posedge clk)
    if (reset) begin
      state_q <= S_IDLE;
      quad_q  <= Q_TL;
      ox_q    <= '0;
      oy_q    <= '0;
      base_q  <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      quad_q  <= quad_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end

  // quad bit 1 selects the row below, bit 0 the tile to the right
  assign bus.mem_addr  = base_q + (quad_q[1] ? ADDR_W'(ROW_TILES) : '0) + ADDR_W'(quad_q[0]);
  assign bus.busy      = busy_q;
  assign bus.mem_req   = req_q;
  assign bus.out_valid = valid_q;
  assign bus.window    = acc_q;
endmodule

// File: tb/tb_window_gather.sv
// tb_window_gather: scoreboard bench for window_gather with a behavioural tile memory.
module tb_window_gather;
  import window_gather_pkg::*;
  localparam int ADDR_W    = 12;
  localparam int ROW_TILES = 40;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clk_en = 1'b1;
  logic toggle_en = 1'b0;
  logic [127:0] rdata_r = '0;
  int tests = 0;
  int fails = 0;
  int grants = 0;
  int outs = 0;
  logic [127:0] exp_win_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic p_req = 1'b0, p_gfire = 1'b0, p_val = 1'b0, p_ofire = 1'b0;
  logic [ADDR_W-1:0] p_addr = '0;
  logic [127:0] p_win = '0;

  window_gather_if #(.ADDR_W(ADDR_W)) bus ();

  window_gather #(.ADDR_W(ADDR_W), .ROW_TILES(ROW_TILES)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] tile_of(logic [11:0] a);
    if (a == 12'h010) return 128'h0123456789ABCDEF0123456789ABCDEF;
    return {a, 4'h1, ~a[7:0], 8'(a * 3), a ^ 12'h5A5, 4'h2, a[7:0], 8'(a * 7 + 1),
            ~a, 4'h3, a[11:4], 8'(a + 13), a ^ 12'hC3C, 4'h4, ~a[11:4], 8'(a * 5 + 9)};
  endfunction

  // builds the full 16x16 pixel field, then cuts the window out of it
  function automatic logic [127:0] model(logic [11:0] b, logic [2:0] ox, logic [2:0] oy);
    logic [1:0] f[16][16];
    logic [127:0] t[4];
    logic [127:0] w = '0;
    t[0] = tile_of(b);
    t[1] = tile_of(12'(b + 1));
    t[2] = tile_of(12'(b + ROW_TILES));
    t[3] = tile_of(12'(b + ROW_TILES + 1));
    for (int q = 0; q < 4; q++)
      for (int tr = 0; tr < 8; tr++)
        for (int tc = 0; tc < 8; tc++)
          f[8*(q/2)+tr][8*(q%2)+tc] = t[q][16*tr+2*tc +: 2];
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        w[16*r+2*c +: 2] = f[r+int'(oy)][c+int'(ox)];
    return w;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got no response, expected one", name);
  endtask

  // tile memory: data is valid on the enabled cycle after req&gnt, junk otherwise
  always @(posedge clk)
    if (clk_en) rdata_r <= (bus.mem_req && bus.mem_gnt) ? tile_of(bus.mem_addr) : {4{32'hBAD0F00D}};
  assign bus.mem_rdata = rdata_r;

  always @(posedge clk) begin
    #1;
    clk_en = toggle_en ? ~clk_en : 1'b1;
  end

  always @(negedge clk) begin
    if (clk_en && bus.mem_req && bus.mem_gnt) begin
      grants++;
      if (exp_addr_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL fetch_addr: got unexpected fetch at %h, expected none", bus.mem_addr);
      end else check("fetch_addr", 128'(bus.mem_addr), 128'(exp_addr_q.pop_front()));
    end
    if (clk_en && bus.out_valid && bus.out_ready) begin
      outs++;
      if (exp_win_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL window: got unexpected window %h, expected none", bus.window);
      end else check("window", bus.window, exp_win_q.pop_front());
    end
    if (bus.mem_req && p_req && !p_gfire) check("addr_stable", 128'(bus.mem_addr), 128'(p_addr));
    if (bus.out_valid && p_val && !p_ofire) check("win_stable", bus.window, p_win);
    p_req   = bus.mem_req;
    p_gfire = clk_en && bus.mem_req && bus.mem_gnt;
    p_addr  = bus.mem_addr;
    p_val   = bus.out_valid;
    p_ofire = clk_en && bus.out_valid && bus.out_ready;
    p_win   = bus.window;
  end

  task automatic expect_fetches(input logic [11:0] b, input logic [2:0] ox, input logic [2:0] oy,
                                input logic [127:0] w);
    exp_addr_q.push_back(b);
    if (ox != 0) exp_addr_q.push_back(12'(b + 1));
    if (oy != 0) exp_addr_q.push_back(12'(b + ROW_TILES));
    if (ox != 0 && oy != 0) exp_addr_q.push_back(12'(b + ROW_TILES + 1));
    exp_win_q.push_back(w);
  endtask

  // called at posedge+1 with the DUT idle; returns at posedge+1 after the window is taken
  task automatic run(input logic [11:0] b, input logic [2:0] ox, input logic [2:0] oy,
                     input logic [127:0] w, input int n, input bit lat, input bit stress);
    int g0, o0, cnt, stall, hold;
    g0 = grants;
    o0 = outs;
    stall = 0;
    hold = 0;
    expect_fetches(b, ox, oy, w);
    bus.tile_base = b;
    bus.offset_x = ox;
    bus.offset_y = oy;
    bus.start = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!bus.busy && cnt < 50);
    if (!bus.busy) fail("accept");
    bus.start = 1'b0;
    bus.tile_base = ~b;
    bus.offset_x = ~ox;
    bus.offset_y = 3'(oy + 3);
    cnt = 1;
    while (!bus.out_valid && cnt < 300) begin
      if (stress && bus.mem_req && bus.mem_addr == 12'(b + 1) && stall < 3) begin
        bus.mem_gnt = 1'b0;
        stall++;
      end else bus.mem_gnt = 1'b1;
      bus.start = stress && bus.mem_req;
      @(posedge clk);
      #1;
      cnt++;
    end
    bus.start = 1'b0;
    bus.mem_gnt = 1'b1;
    if (!bus.out_valid) fail("out_valid");
    else if (lat) check("latency", 128'(cnt), 128'(2 * n + 1));
    cnt = 0;
    while (outs == o0 && cnt < 300) begin
      bus.out_ready = !(stress && bus.out_valid && hold < 4);
      if (!bus.out_ready) hold++;
      @(posedge clk);
      #1;
      cnt++;
    end
    bus.out_ready = 1'b1;
    if (outs == o0) fail("handoff");
    check("n_fetch", 128'(grants - g0), 128'(n));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.offset_x = '0;
    bus.offset_y = '0;
    bus.tile_base = '0;
    bus.mem_gnt = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_req", 128'(bus.mem_req), 128'(0));
    check("rst_addr", 128'(bus.mem_addr), 128'(0));
    check("rst_valid", 128'(bus.out_valid), 128'(0));
    check("rst_window", bus.window, 128'(0));
    @(posedge clk);
    #1;
    run(12'h010, 3'd0, 3'd0, 128'h0123456789ABCDEF0123456789ABCDEF, 1, 1'b1, 1'b0);
    run(12'h100, 3'd3, 3'd5, model(12'h100, 3'd3, 3'd5), 4, 1'b1, 1'b0);
    run(12'h200, 3'd4, 3'd0, model(12'h200, 3'd4, 3'd0), 2, 1'b1, 1'b0);
    run(12'h300, 3'd0, 3'd6, model(12'h300, 3'd0, 3'd6), 2, 1'b1, 1'b0);
    run(12'hFFF, 3'd1, 3'd1, model(12'hFFF, 3'd1, 3'd1), 4, 1'b1, 1'b0);
    run(12'h7C0, 3'd7, 3'd7, model(12'h7C0, 3'd7, 3'd7), 4, 1'b1, 1'b0);
    toggle_en = 1'b1;
    run(12'h0A5, 3'd6, 3'd3, model(12'h0A5, 3'd6, 3'd3), 4, 1'b0, 1'b1);
    run(12'h444, 3'd2, 3'd0, model(12'h444, 3'd2, 3'd0), 2, 1'b0, 1'b1);
    toggle_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_fetches(12'h100, 3'd3, 3'd5, 128'(0));
    bus.tile_base = 12'h100;
    bus.offset_x = 3'd3;
    bus.offset_y = 3'd5;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("mid_rst_busy", 128'(bus.busy), 128'(0));
    check("mid_rst_req", 128'(bus.mem_req), 128'(0));
    check("mid_rst_valid", 128'(bus.out_valid), 128'(0));
    check("mid_rst_window", bus.window, 128'(0));
    check("mid_rst_fetches", 128'(exp_addr_q.size()), 128'(2));
    exp_addr_q.delete();
    exp_win_q.delete();
    run(12'h100, 3'd3, 3'd5, model(12'h100, 3'd3, 3'd5), 4, 1'b1, 1'b0);
    check("sb_empty", 128'(exp_addr_q.size() + exp_win_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
